wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 97 +++++++++
 tb/tb_wb_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter: the pipeline has fixed priority, and an aux
// request that waits too long is forced through for one cycle.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic [63:0] p_pc,
  input  logic [4:0]  p_rd,
  input  logic [63:0] p_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [63:0] a_pc,
  input  logic [4:0]  a_rd,
  input  logic [63:0] a_data,
  output logic        wb_en,
  output logic [63:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        starve
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LP_STARVE_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             w_p_xfer;
  logic             w_a_xfer;

  // Handshake: FORCE hands the port to aux, otherwise the pipeline wins.
  always_comb begin
    p_ready = (r_state == ST_NORMAL);
    a_ready = (r_state == ST_FORCE) || !p_valid;
  end

  assign w_p_xfer = p_valid && p_ready;
  assign w_a_xfer = a_valid && a_ready;
  assign starve   = (r_state == ST_FORCE);

  // Starvation counter only advances while aux is blocked; reaching the limit
  // moves to FORCE and the counter restarts from zero.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    if (r_state == ST_NORMAL) begin
      if (a_valid && !a_ready) begin
        if ((r_wait_cnt + CNT_W'(1)) >= LP_STARVE_MAX) begin
          w_state_nxt = ST_FORCE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
    end else begin
      if (w_a_xfer || !a_valid) begin
        w_state_nxt = ST_NORMAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_NORMAL;
      r_wait_cnt <= '0;
      wb_en      <= 1'b0;
      wb_pc      <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_p_xfer) begin
        wb_en   <= (p_rd != 5'd0);
        wb_pc   <= p_pc;
        wb_rd   <= p_rd;
        wb_data <= p_data;
      end else if (w_a_xfer) begin
        wb_en   <= (a_rd != 5'd0);
        wb_pc   <= a_pc;
        wb_rd   <= a_rd;
        wb_data <= a_data;
      end else begin
        wb_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one instance at STARVE_MAX=4 and one at 1,
// both fed from the same requester stimulus.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid, a_valid;
  logic [63:0] p_pc, p_data, a_pc, a_data;
  logic [4:0]  p_rd, a_rd;

  logic        p_ready, a_ready, wb_en, starve;
  logic [63:0] wb_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        p_ready1, a_ready1, wb_en1, starve1;
  logic [63:0] wb_pc1, wb_data1;
  logic [4:0]  wb_rd1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_ready(p_ready), .p_pc(p_pc), .p_rd(p_rd), .p_data(p_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_pc(a_pc), .a_rd(a_rd), .a_data(a_data),
    .wb_en(wb_en), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .starve(starve)
  );

  wb_arbiter #(.STARVE_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_ready(p_ready1), .p_pc(p_pc), .p_rd(p_rd), .p_data(p_data),
    .a_valid(a_valid), .a_ready(a_ready1), .a_pc(a_pc), .a_rd(a_rd), .a_data(a_data),
    .wb_en(wb_en1), .wb_pc(wb_pc1), .wb_rd(wb_rd1), .wb_data(wb_data1), .starve(starve1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    p_valid = 1'b0; p_pc = '0; p_rd = '0; p_data = '0;
    a_valid = 1'b0; a_pc = '0; a_rd = '0; a_data = '0;
    #12;
    // Reset values and NORMAL-style readies while held in reset
    chk("rst_wb_en",   64'(wb_en),   64'd0);
    chk("rst_wb_rd",   64'(wb_rd),   64'd0);
    chk("rst_wb_data", wb_data,      64'd0);
    chk("rst_wb_pc",   wb_pc,        64'd0);
    chk("rst_starve",  64'(starve),  64'd0);
    chk("rst_p_ready", 64'(p_ready), 64'd1);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    p_valid = 1'b1; p_rd = 5'd7; p_data = 64'hbeef;
    #1;
    chk("rst_a_ready_pv", 64'(a_ready), 64'd0);
    tick();
    chk("rst_no_xfer_en",   64'(wb_en), 64'd0);
    chk("rst_no_xfer_data", wb_data,    64'd0);
    p_valid = 1'b0;
    rst_n = 1'b1;

    // Idle after release
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_wb_en",   64'(wb_en),  64'd0);
      chk("idle_wb_data", wb_data,     64'd0);
      chk("idle_starve",  64'(starve), 64'd0);
    end

    // Single pipeline write
    p_valid = 1'b1; p_rd = 5'd5; p_data = 64'h1234; p_pc = 64'h8000_0000;
    #1;
    chk("p1_p_ready", 64'(p_ready), 64'd1);
    tick();
    p_valid = 1'b0;
    chk("p1_wb_en",   64'(wb_en), 64'd1);
    chk("p1_wb_rd",   64'(wb_rd), 64'd5);
    chk("p1_wb_data", wb_data,    64'h1234);
    chk("p1_wb_pc",   wb_pc,      64'h8000_0000);
    tick();
    chk("p1_after_en",   64'(wb_en), 64'd0);
    chk("p1_hold_data",  wb_data,    64'h1234);
    chk("p1_hold_rd",    64'(wb_rd), 64'd5);

    // rd == 0 accepted, no write, payload still captured
    p_valid = 1'b1; p_rd = 5'd0; p_data = 64'hdead; p_pc = 64'h8000_0004;
    #1;
    chk("rd0_p_ready", 64'(p_ready), 64'd1);
    tick();
    p_valid = 1'b0;
    chk("rd0_wb_en",   64'(wb_en), 64'd0);
    chk("rd0_wb_data", wb_data,    64'hdead);
    chk("rd0_wb_pc",   wb_pc,      64'h8000_0004);

    // Aux alone: immediate acceptance, back-to-back writes, never starves
    a_valid = 1'b1; a_rd = 5'd10; a_data = 64'h55; a_pc = 64'h100;
    #1;
    chk("aux_a_ready", 64'(a_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aux_wb_en",   64'(wb_en),  64'd1);
      chk("aux_wb_rd",   64'(wb_rd),  64'd10);
      chk("aux_wb_data", wb_data,     64'h55 + 64'(i));
      chk("aux_starve",  64'(starve), 64'd0);
      chk("aux_starve1", 64'(starve1), 64'd0);
      a_data = 64'h55 + 64'(i + 1);
    end
    a_valid = 1'b0;
    tick();
    chk("aux_done_en", 64'(wb_en), 64'd0);

    // Both held: period 5 at STARVE_MAX=4, period 2 at STARVE_MAX=1
    p_valid = 1'b1; p_rd = 5'd1; p_data = 64'h11; p_pc = 64'h1000;
    a_valid = 1'b1; a_rd = 5'd2; a_data = 64'h22; a_pc = 64'h2000;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("both_starve",   64'(starve),   64'((k % 5) == 4));
      chk("both_p_ready",  64'(p_ready),  64'((k % 5) != 4));
      chk("both_a_ready",  64'(a_ready),  64'((k % 5) == 4));
      chk("both_starve1",  64'(starve1),  64'((k % 2) == 1));
      tick();
      chk("both_wb_en",    64'(wb_en),    64'd1);
      chk("both_wb_rd",    64'(wb_rd),    ((k % 5) == 4) ? 64'd2 : 64'd1);
      chk("both_wb_pc",    wb_pc,         ((k % 5) == 4) ? 64'h2000 : 64'h1000);
      chk("both_wb_rd1",   64'(wb_rd1),   ((k % 2) == 1) ? 64'd2 : 64'd1);
      chk("both_wb_data1", wb_data1,      ((k % 2) == 1) ? 64'h22 : 64'h11);
      chk("both_wb_pc1",   wb_pc1,        ((k % 2) == 1) ? 64'h2000 : 64'h1000);
    end

    // Enter FORCE, then asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) tick();
    chk("frc_starve", 64'(starve), 64'd1);
    chk("frc_wb_en",  64'(wb_en),  64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_starve", 64'(starve), 64'd0);
    chk("arst_wb_en",  64'(wb_en),  64'd0);
    chk("arst_wb_rd",  64'(wb_rd),  64'd0);
    tick();
    chk("arst_edge_en", 64'(wb_en), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_p_ready", 64'(p_ready), 64'd1);
    chk("rel_a_ready", 64'(a_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rel_wb_rd",  64'(wb_rd),  64'd1);
      chk("rel_starve", 64'(starve), 64'(i == 4));
      if (i == 1) chk("rel_starve1", 64'(starve1), 64'd1);
    end
    p_valid = 1'b0; a_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
